// File: rtl/lsu_dm.sv
// ============================================================================
//  Module   : lsu_dm
//  Brief    : Load/store unit between execute and the main_mem data port.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module lsu_dm (
    input  logic        clk,
    input  logic        i_rst,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_store,
    input  logic [1:0]  i_req_size,
    input  logic        i_req_unsigned,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    input  logic [4:0]  i_req_rd,
    output logic        o_dm_ren,
    output logic        o_dm_wen,
    output logic [3:0]  o_dm_ben,
    output logic [13:0] o_dm_addr,
    output logic [31:0] o_dm_wdata,
    input  logic [31:0] i_dm_rdata,
    input  logic        i_mem_ready,
    output logic        o_rsp_valid,
    output logic        o_rsp_we,
    output logic [4:0]  o_rsp_rd,
    output logic [31:0] o_rsp_data,
    output logic [1:0]  o_rsp_fault
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t      state_q;
    logic        store_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [1:0]  off_q;
    logic [4:0]  rd_q;
    logic [13:0] dm_addr_q;
    logic [3:0]  dm_ben_q;
    logic [31:0] dm_wdata_q;
    logic        rsp_valid_q;
    logic        rsp_we_q;
    logic [4:0]  rsp_rd_q;
    logic [31:0] rsp_data_q;
    logic [1:0]  rsp_fault_q;

    logic        accept;
    logic [1:0]  fault_d;
    logic [3:0]  ben_d;
    logic [31:0] wdata_d;
    logic [31:0] ld_data_d;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    assign accept = i_req_valid && (state_q == S_IDLE);

    // Fault priority: illegal size, then misalignment, then range.
    always_comb begin
        fault_d = 2'b00;
        if (i_req_size == 2'b11)
            fault_d = 2'b11;
        else if ((i_req_size == 2'b01 && i_req_addr[0]) ||
                 (i_req_size == 2'b10 && i_req_addr[1:0] != 2'b00))
            fault_d = 2'b01;
        else if (i_req_addr[31:16] != 16'h0000)
            fault_d = 2'b10;
    end

    always_comb begin
        ben_d   = 4'b1111;
        wdata_d = i_req_wdata;
        case (i_req_size)
            2'b00: begin
                ben_d   = 4'b0001 << i_req_addr[1:0];
                wdata_d = {4{i_req_wdata[7:0]}};
            end
            2'b01: begin
                ben_d   = i_req_addr[1] ? 4'b1100 : 4'b0011;
                wdata_d = {2{i_req_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        ld_byte   = i_dm_rdata[{off_q, 3'b000} +: 8];
        ld_half   = i_dm_rdata[{off_q[1], 4'b0000} +: 16];
        ld_data_d = i_dm_rdata;
        case (size_q)
            2'b00:   ld_data_d = {{24{ld_byte[7] & ~uns_q}}, ld_byte};
            2'b01:   ld_data_d = {{16{ld_half[15] & ~uns_q}}, ld_half};
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            store_q     <= 1'b0;
            size_q      <= 2'b00;
            uns_q       <= 1'b0;
            off_q       <= 2'b00;
            rd_q        <= 5'd0;
            dm_addr_q   <= 14'd0;
            dm_ben_q    <= 4'd0;
            dm_wdata_q  <= 32'd0;
            rsp_valid_q <= 1'b0;
            rsp_we_q    <= 1'b0;
            rsp_rd_q    <= 5'd0;
            rsp_data_q  <= 32'd0;
            rsp_fault_q <= 2'b00;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        store_q    <= i_req_store;
                        size_q     <= i_req_size;
                        uns_q      <= i_req_unsigned;
                        off_q      <= i_req_addr[1:0];
                        rd_q       <= i_req_rd;
                        dm_addr_q  <= i_req_addr[15:2];
                        dm_ben_q   <= ben_d;
                        dm_wdata_q <= wdata_d;
                        if (fault_d != 2'b00) begin
                            state_q     <= S_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_we_q    <= 1'b0;
                            rsp_rd_q    <= i_req_rd;
                            rsp_data_q  <= i_req_addr;
                            rsp_fault_q <= fault_d;
                        end else begin
                            state_q <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    if (i_mem_ready) begin
                        if (store_q) begin
                            state_q     <= S_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_we_q    <= 1'b0;
                            rsp_rd_q    <= rd_q;
                            rsp_data_q  <= 32'd0;
                            rsp_fault_q <= 2'b00;
                        end else begin
                            state_q <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    state_q     <= S_RESP;
                    rsp_valid_q <= 1'b1;
                    rsp_we_q    <= (rd_q != 5'd0);
                    rsp_rd_q    <= rd_q;
                    rsp_data_q  <= ld_data_d;
                    rsp_fault_q <= 2'b00;
                end
                S_RESP: begin
                    state_q     <= S_IDLE;
                    rsp_valid_q <= 1'b0;
                    rsp_we_q    <= 1'b0;
                    rsp_rd_q    <= 5'd0;
                    rsp_data_q  <= 32'd0;
                    rsp_fault_q <= 2'b00;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Strobes stay combinational so a stalled port never sees a request.
    assign o_dm_ren    = (state_q == S_ISSUE) && !store_q && i_mem_ready;
    assign o_dm_wen    = (state_q == S_ISSUE) &&  store_q && i_mem_ready;
    assign o_req_ready = (state_q == S_IDLE);
    assign o_dm_addr   = dm_addr_q;
    assign o_dm_ben    = dm_ben_q;
    assign o_dm_wdata  = dm_wdata_q;
    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_we    = rsp_we_q;
    assign o_rsp_rd    = rsp_rd_q;
    assign o_rsp_data  = rsp_data_q;
    assign o_rsp_fault = rsp_fault_q;

endmodule

`default_nettype wire

// File: tb/tb_lsu_dm.sv
// ============================================================================
//  Module   : tb_lsu_dm
//  Brief    : Randomized self-checking bench for lsu_dm with a memory model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_lsu_dm;

    logic        clk = 1'b0;
    logic        i_rst;
    logic        i_req_valid, o_req_ready, i_req_store, i_req_unsigned;
    logic [1:0]  i_req_size;
    logic [31:0] i_req_addr, i_req_wdata;
    logic [4:0]  i_req_rd;
    logic        o_dm_ren, o_dm_wen;
    logic [3:0]  o_dm_ben;
    logic [13:0] o_dm_addr;
    logic [31:0] o_dm_wdata, i_dm_rdata;
    logic        i_mem_ready;
    logic        o_rsp_valid, o_rsp_we;
    logic [4:0]  o_rsp_rd;
    logic [31:0] o_rsp_data;
    logic [1:0]  o_rsp_fault;

    always #5 clk = ~clk;

    lsu_dm dut (
        .clk(clk), .i_rst(i_rst),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_store(i_req_store), .i_req_size(i_req_size),
        .i_req_unsigned(i_req_unsigned), .i_req_addr(i_req_addr),
        .i_req_wdata(i_req_wdata), .i_req_rd(i_req_rd),
        .o_dm_ren(o_dm_ren), .o_dm_wen(o_dm_wen), .o_dm_ben(o_dm_ben),
        .o_dm_addr(o_dm_addr), .o_dm_wdata(o_dm_wdata),
        .i_dm_rdata(i_dm_rdata), .i_mem_ready(i_mem_ready),
        .o_rsp_valid(o_rsp_valid), .o_rsp_we(o_rsp_we), .o_rsp_rd(o_rsp_rd),
        .o_rsp_data(o_rsp_data), .o_rsp_fault(o_rsp_fault)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit mem_init;
    logic [31:0] mem     [0:63];
    logic [31:0] ref_mem [0:63];

    function automatic logic [31:0] init_word(input int i);
        return (i == 3) ? 32'hDEADBEEF : (32'(i) * 32'h9E3779B9) ^ 32'h5A5A0000;
    endfunction

    // Data-memory side: read data the cycle after ren, byte-lane writes.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
        end else begin
            if (o_dm_ren) i_dm_rdata <= mem[o_dm_addr[5:0]];
            if (o_dm_wen)
                for (int b = 0; b < 4; b++)
                    if (o_dm_ben[b]) mem[o_dm_addr[5:0]][8*b +: 8] <= o_dm_wdata[8*b +: 8];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] exp_fault(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'd3) return 2'b11;
        if ((sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0)) return 2'b01;
        if (a >= 32'h10000) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [31:0] load_value(input logic [1:0] sz, input bit un, input logic [31:0] a);
        logic [31:0] w, v;
        int sh;
        w  = ref_mem[a[7:2]];
        sh = 8 * int'(a % 4);
        if (sz == 2'd0) begin
            v = (w >> sh) & 32'hFF;
            if (!un && v >= 32'h80) v = v | 32'hFFFFFF00;
        end else if (sz == 2'd1) begin
            v = (w >> sh) & 32'hFFFF;
            if (!un && v >= 32'h8000) v = v | 32'hFFFF0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    task automatic ref_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] mask;
        int sh;
        sh   = 8 * int'(a % 4);
        mask = (sz == 2'd0) ? (32'hFF << sh) : (sz == 2'd1) ? (32'hFFFF << sh) : 32'hFFFFFFFF;
        ref_mem[a[7:2]] = (ref_mem[a[7:2]] & ~mask) | ((wd << sh) & mask);
    endtask

    task automatic do_req(input bit st, input logic [1:0] sz, input bit un, input logic [31:0] a,
                          input logic [31:0] wd, input logic [4:0] rd, input int stall,
                          output logic [31:0] data_o);
        logic [1:0]  ef;
        logic [3:0]  eben;
        logic [31:0] ewd, edata;
        bit          ewe, done;
        int          elat, nstb;
        ef    = exp_fault(sz, a);
        elat  = (ef != 2'b00) ? 1 : (st ? 2 + stall : 3 + stall);
        eben  = (sz == 2'd0) ? (4'b0001 << a[1:0]) : (sz == 2'd1) ? (4'b0011 << a[1:0]) : 4'hF;
        ewd   = (sz == 2'd0) ? wd[7:0] * 32'h01010101 : (sz == 2'd1) ? wd[15:0] * 32'h00010001 : wd;
        if (ef != 2'b00)  begin edata = a;  ewe = 1'b0; end
        else if (st)      begin edata = 0;  ewe = 1'b0; end
        else              begin edata = load_value(sz, un, a); ewe = (rd != 5'd0); end
        data_o = 32'hX;
        @(negedge clk);
        check("req_ready_idle", o_req_ready, 1);
        i_req_valid = 1; i_req_store = st; i_req_size = sz; i_req_unsigned = un;
        i_req_addr = a; i_req_wdata = wd; i_req_rd = rd; i_mem_ready = 1;
        nstb = 0; done = 0;
        for (int k = 1; k <= 40 && !done; k++) begin
            @(negedge clk);
            if (k == 1) begin
                i_req_valid = $urandom_range(0, 1); i_req_store = $urandom_range(0, 1);
                i_req_addr = $urandom; i_req_wdata = $urandom; i_req_size = 2'($urandom);
            end
            i_mem_ready = (nstb != 0) ? 1'($urandom) : ((k <= stall) ? 1'b0 : 1'b1);
            #1;
            if (!i_mem_ready) check("strobe_while_stalled", {o_dm_ren, o_dm_wen}, 0);
            if (o_dm_ren || o_dm_wen) begin
                nstb++;
                check("strobe_kind", {o_dm_ren, o_dm_wen}, st ? 2'b01 : 2'b10);
                check("dm_addr", o_dm_addr, a[15:2]);
                if (st) begin
                    check("dm_ben", o_dm_ben, eben);
                    check("dm_wdata", o_dm_wdata, ewd);
                end
            end
            if (o_rsp_valid) begin
                done = 1;
                check("rsp_latency", k, elat);
                check("rsp_fault", o_rsp_fault, ef);
                check("rsp_we", o_rsp_we, ewe);
                check("rsp_data", o_rsp_data, edata);
                if (ewe) check("rsp_rd", o_rsp_rd, rd);
                data_o = o_rsp_data;
            end
        end
        i_req_valid = 0;
        if (!done) check("rsp_timeout", 0, 1);
        check("strobe_count", nstb, (ef == 2'b00) ? 1 : 0);
        if (ef == 2'b00 && st) ref_store(sz, a, wd);
        @(negedge clk);
        i_mem_ready = 1;
        #1;
        check("rsp_single_pulse", o_rsp_valid, 0);
        check("ready_after_rsp", o_req_ready, 1);
    endtask

    initial begin
        logic [31:0] d;
        logic [31:0] a;
        logic [1:0]  sz;
        for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
        mem_init = 1; i_rst = 1; i_req_valid = 0; i_req_store = 0; i_req_size = 0;
        i_req_unsigned = 0; i_req_addr = 0; i_req_wdata = 0; i_req_rd = 0; i_mem_ready = 1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_req_ready", o_req_ready, 1);
        check("rst_strobes", {o_dm_ren, o_dm_wen}, 0);
        check("rst_dm_addr", o_dm_addr, 0);
        check("rst_dm_ben", o_dm_ben, 0);
        check("rst_dm_wdata", o_dm_wdata, 0);
        check("rst_rsp", {o_rsp_valid, o_rsp_we, o_rsp_rd, o_rsp_fault}, 0);
        check("rst_rsp_data", o_rsp_data, 0);
        mem_init = 0; i_rst = 0;

        do_req(0, 2'd2, 0, 32'h0C, 0, 5'd5, 0, d); check("lw_const", d, 32'hDEADBEEF);
        do_req(0, 2'd0, 0, 32'h0E, 0, 5'd6, 0, d); check("lb_const", d, 32'hFFFFFFAD);
        do_req(0, 2'd0, 1, 32'h0E, 0, 5'd6, 0, d); check("lbu_const", d, 32'h000000AD);
        do_req(0, 2'd1, 1, 32'h0E, 0, 5'd6, 0, d); check("lhu_const", d, 32'h0000DEAD);
        do_req(1, 2'd1, 0, 32'h22, 32'h12345678, 5'd0, 0, d);
        do_req(0, 2'd2, 0, 32'h20, 0, 5'd1, 0, d); check("sh_readback_hi", d[31:16], 16'h5678);
        do_req(0, 2'd2, 0, 32'h11, 0, 5'd2, 0, d); check("lw_misaligned_addr", d, 32'h11);
        do_req(1, 2'd0, 0, 32'h00010000, 32'hAB, 5'd0, 0, d);
        do_req(0, 2'd3, 0, 32'h3, 0, 5'd3, 0, d);
        do_req(0, 2'd2, 0, 32'h0C, 0, 5'd4, 5, d);

        // Reset while the load sits in WAIT: its response must vanish.
        @(negedge clk);
        i_req_valid = 1; i_req_store = 0; i_req_size = 2'd2; i_req_addr = 32'h0C; i_req_rd = 5'd7;
        @(negedge clk); i_req_valid = 0; i_mem_ready = 1;
        @(negedge clk); #1; check("wait_no_rsp", o_rsp_valid, 0);
        i_rst = 1;
        @(negedge clk); i_rst = 0; #1;
        check("rst_mid_ready", o_req_ready, 1);
        check("rst_mid_no_rsp", o_rsp_valid, 0);
        repeat (3) begin @(negedge clk); #1; check("rst_mid_no_late_rsp", o_rsp_valid, 0); end
        do_req(0, 2'd2, 0, 32'h0C, 0, 5'd7, 0, d); check("lw_after_reset", d, 32'hDEADBEEF);

        for (int n = 0; n < 250; n++) begin
            sz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            a  = ($urandom_range(0, 9) == 0) ? ($urandom | 32'h00010000) : 32'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0 && sz != 2'd3)
                a = a & ~((sz == 2'd2) ? 32'h3 : (sz == 2'd1) ? 32'h1 : 32'h0);
            do_req(1'($urandom), sz, 1'($urandom), a, $urandom, 5'($urandom),
                   $urandom_range(0, 3), d);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
